// File: rtl/prng8_checker_if.sv
// Receive-side PRNG checker bus: word stream and clear in, lock/error status out.
interface prng8_checker_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             clear;
  logic             locked;
  logic             err;
  logic             match;
  logic [CNT_W-1:0] err_cnt;
  logic [WIDTH-1:0] expected;

  modport master (
    output valid, data, clear,
    input  locked, err, match, err_cnt, expected
  );

  modport slave (
    input  valid, data, clear,
    output locked, err, match, err_cnt, expected
  );
endinterface

// File: rtl/prng8_checker.sv
// Regenerates the 8-bit PRNG sequence locally from the first non-zero received word,
// confirms lock over LOCK_CNT matches, flywheels through errors and counts them.
module prng8_checker #(
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 16
) (
  input  logic           clk,
  input  logic           nRst,
  prng8_checker_if.slave bus
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);

  // Must stay bit-identical to the transmit-side PRNG update.
  function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] x);
    return {x[3] ^ x[4] ^ x[2] ^ x[1], x[7:1]};
  endfunction

  state_t           state;
  logic [3:0]       good;
  logic [3:0]       bad;
  logic             locked_q;
  logic             err_q;
  logic             match_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [WIDTH-1:0] expected_q;

  logic             hit;
  logic [3:0]       good_inc;
  logic [3:0]       bad_inc;

  assign hit      = (bus.data == expected_q);
  assign good_inc = good + 4'd1;
  assign bad_inc  = bad + 4'd1;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state      <= HUNT;
      good       <= '0;
      bad        <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      match_q    <= 1'b0;
      err_cnt_q  <= '0;
      expected_q <= '0;
    end else begin
      err_q   <= 1'b0;
      match_q <= 1'b0;

      if (bus.valid) begin
        case (state)
          HUNT: begin
            if (bus.data != '0) begin
              expected_q <= nxt(bus.data);
              good       <= '0;
              state      <= VERIFY;
            end
          end

          VERIFY: begin
            if (hit) begin
              match_q    <= 1'b1;
              expected_q <= nxt(bus.data);
              good       <= good_inc;
              if (good_inc == LOCK_N) begin
                state    <= LOCKED;
                locked_q <= 1'b1;
                bad      <= '0;
              end
            end else if (bus.data != '0) begin
              // Reseed on the received word; errors before lock are not counted.
              expected_q <= nxt(bus.data);
              good       <= '0;
            end else begin
              state <= HUNT;
              good  <= '0;
            end
          end

          LOCKED: begin
            // Flywheel on the local sequence so a corrupted word cannot derail it.
            expected_q <= nxt(expected_q);
            if (hit) begin
              match_q <= 1'b1;
              bad     <= '0;
            end else begin
              err_q <= 1'b1;
              bad   <= bad_inc;
              if (err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + 1'b1;
              end
              if (bad_inc == LOSS_N) begin
                state    <= HUNT;
                locked_q <= 1'b0;
              end
            end
          end

          default: begin
            state    <= HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end

      // Clear wins over a same-cycle increment.
      if (bus.clear) begin
        err_cnt_q <= '0;
      end
    end
  end

  assign bus.locked   = locked_q;
  assign bus.err      = err_q;
  assign bus.match    = match_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.expected = expected_q;

endmodule
